// File: rtl/led_scan_mux.sv
// led_scan_mux: 4-digit multiplexed LED scanner with inter-digit blanking and per-frame snapshot.
// Optional LED_SCAN_BRIGHTNESS_EN adds a Bright[2:0] duty control.
module led_scan_mux #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       En,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [2:0] Bright,
`endif
  input  logic [0:7] LED1,
  input  logic [0:7] LED2,
  input  logic [0:7] LED3,
  input  logic [0:7] LED4,
  output logic [3:0] AN,
  output logic [0:7] SEG,
  output logic       FrameTick
);

  localparam int MAXV =
    (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW = (MAXV > 2) ? $clog2(MAXV) : 1;

  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLAST = CW'(SCAN_DIV - 1);

  typedef enum logic {
    BLANK,
    SHOW
  } st_t;

  st_t           st, nst;
  logic [1:0]    idx, nidx;
  logic [CW-1:0] cnt, ncnt;
  logic [0:7]    snap  [4];
  logic [0:7]    nsnap [4];
  logic          lit;
  logic [3:0]    an_n;
  logic [0:7]    seg_n;
  logic          ft_n;

`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [2:0]  br, nbr;
  logic [31:0] thr;
`endif

  // Next-state, including the once-per-frame snapshot
  always_comb begin
    nst   = st;
    nidx  = idx;
    ncnt  = cnt;
    nsnap = snap;
`ifdef LED_SCAN_BRIGHTNESS_EN
    nbr   = br;
`endif
    if (!En) begin
      nst  = BLANK;
      nidx = 2'd0;
      ncnt = '0;
    end else begin
      if (st == BLANK && idx == 2'd0 && cnt == '0) begin
        nsnap[0] = LED4;
        nsnap[1] = LED3;
        nsnap[2] = LED2;
        nsnap[3] = LED1;
`ifdef LED_SCAN_BRIGHTNESS_EN
        nbr      = Bright;
`endif
      end
      unique case (st)
        BLANK: begin
          if (cnt == BLAST) begin
            nst  = SHOW;
            ncnt = '0;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SLAST) begin
            nst  = BLANK;
            ncnt = '0;
            nidx = idx + 2'd1;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        default: begin
          nst  = BLANK;
          ncnt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next state so they align with it
  always_comb begin
`ifdef LED_SCAN_BRIGHTNESS_EN
    thr = ((32'(nbr) + 32'd1) * 32'(SCAN_DIV)) >> 3;
    lit = (32'(ncnt) < thr);
`else
    lit = 1'b1;
`endif
    an_n  = 4'b1111;
    seg_n = 8'hFF;
    ft_n  = 1'b0;
    if (nst == SHOW) begin
      if (lit) begin
        an_n[nidx] = 1'b0;
        seg_n      = nsnap[nidx];
      end
      ft_n = (nidx == 2'd3) && (ncnt == SLAST);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      st        <= BLANK;
      idx       <= 2'd0;
      cnt       <= '0;
      AN        <= 4'b1111;
      SEG       <= 8'hFF;
      FrameTick <= 1'b0;
      for (int i = 0; i < 4; i++) snap[i] <= 8'hFF;
`ifdef LED_SCAN_BRIGHTNESS_EN
      br        <= 3'd7;
`endif
    end else begin
      st        <= nst;
      idx       <= nidx;
      cnt       <= ncnt;
      AN        <= an_n;
      SEG       <= seg_n;
      FrameTick <= ft_n;
      for (int i = 0; i < 4; i++) snap[i] <= nsnap[i];
`ifdef LED_SCAN_BRIGHTNESS_EN
      br        <= nbr;
`endif
    end
  end

endmodule

// File: tb/tb_led_scan_mux.sv
// tb_led_scan_mux: frame-counter model plus directed checks for led_scan_mux.
// Build with LED_SCAN_BRIGHTNESS_EN to exercise the Bright input.
module tb_led_scan_mux;

  localparam int S  = 8;
  localparam int B  = 2;
  localparam int SL = S + B;
  localparam int FR = 4 * SL;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       En;
  logic [0:7] LED1, LED2, LED3, LED4;
  logic [3:0] AN;
  logic [0:7] SEG;
  logic       FrameTick;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [2:0] Bright;
  logic [2:0] mbr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  led_scan_mux #(.SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .En(En),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .Bright(Bright),
`endif
    .LED1(LED1),
    .LED2(LED2),
    .LED3(LED3),
    .LED4(LED4),
    .AN(AN),
    .SEG(SEG),
    .FrameTick(FrameTick)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: position inside the frame plus the latched patterns
  int         mfc = 0;
  logic       mvalid = 1'b0;
  logic [7:0] msnap [4];

  always @(posedge CLK) begin
    if (!Reset) begin
      mfc    <= 0;
      mvalid <= 1'b1;
      for (int i = 0; i < 4; i++) msnap[i] <= 8'hFF;
`ifdef LED_SCAN_BRIGHTNESS_EN
      mbr    <= 3'd7;
`endif
    end else if (!En) begin
      mfc <= 0;
    end else begin
      if (mfc == 0) begin
        msnap[0] <= LED4;
        msnap[1] <= LED3;
        msnap[2] <= LED2;
        msnap[3] <= LED1;
`ifdef LED_SCAN_BRIGHTNESS_EN
        mbr      <= Bright;
`endif
      end
      mfc <= (mfc + 1) % FR;
    end
  end

  logic [3:0] last_act = 4'hF;
  int         gap = 0;

  always @(negedge CLK) begin
    if (mvalid) begin
      automatic int   slot = mfc / SL;
      automatic int   off  = mfc % SL;
      automatic logic on   = (off >= B);
      automatic logic [3:0] ea;
      automatic logic [7:0] es;
`ifdef LED_SCAN_BRIGHTNESS_EN
      if (on && (off - B) >= (((int'(mbr) + 1) * S) >> 3)) on = 1'b0;
`endif
      ea = 4'hF;
      es = 8'hFF;
      if (on) begin
        ea[slot] = 1'b0;
        es = msnap[slot];
      end
      chk("model_an", AN, ea);
      chk("model_seg", SEG, es);
      chk("model_ft", FrameTick, (mfc == FR - 1));
      chk("onehot", ($countones(~AN) <= 1), 1);
      if (AN == 4'hF) begin
        gap++;
      end else begin
        if (last_act != 4'hF && AN != last_act)
          chk("blank_gap", (gap >= B), 1);
        last_act = AN;
        gap = 0;
      end
    end
  end

  int nft;
  int nlit;

  initial begin
    Reset = 1'b0;
    En    = 1'b1;
    LED1  = 8'h01;
    LED2  = 8'h02;
    LED3  = 8'h04;
    LED4  = 8'h08;
`ifdef LED_SCAN_BRIGHTNESS_EN
    Bright = 3'd7;
`endif
    repeat (3) begin
      @(negedge CLK);
      chk("rst_an", AN, 4'hF);
      chk("rst_seg", SEG, 8'hFF);
      chk("rst_ft", FrameTick, 0);
    end
    Reset = 1'b1;

    // first frame, hand-computed points
    for (int c = 0; c < FR; c++) begin
      case (c)
        0, 1, 10, 11: chk("f1_blank", AN, 4'hF);
        2, 9: begin
          chk("f1_d0_an", AN, 4'hE);
          chk("f1_d0_seg", SEG, 8'h08);
        end
        12, 19: begin
          chk("f1_d1_an", AN, 4'hD);
          chk("f1_d1_seg", SEG, 8'h04);
        end
        22, 29: begin
          chk("f1_d2_an", AN, 4'hB);
          chk("f1_d2_seg", SEG, 8'h02);
        end
        32, 38: begin
          chk("f1_d3_an", AN, 4'h7);
          chk("f1_d3_seg", SEG, 8'h01);
          chk("f1_ft0", FrameTick, 0);
        end
        39: chk("f1_ft1", FrameTick, 1);
        default: ;
      endcase
      @(negedge CLK);
    end

    // five frames of FrameTick
    nft = 0;
    for (int i = 0; i < 5 * FR; i++) begin
      if (FrameTick) begin
        nft++;
        chk("ft_pos", i % FR, FR - 1);
      end
      @(negedge CLK);
    end
    chk("ft_count", nft, 5);

    // tearing: LED4 change mid-frame shows next frame only
    repeat (5) @(negedge CLK);
    LED4 = 8'h55;
    @(negedge CLK);
    chk("tear_an", AN, 4'hE);
    chk("tear_old", SEG, 8'h08);
    repeat (FR - 4) @(negedge CLK);
    chk("tear_an2", AN, 4'hE);
    chk("tear_new", SEG, 8'h55);

    // En drop at frame cycle 25
    repeat (23) @(negedge CLK);
    En = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk("en_an", AN, 4'hF);
      chk("en_seg", SEG, 8'hFF);
    end
    En = 1'b1;
    chk("en_c0", AN, 4'hF);
    @(negedge CLK);
    chk("en_c1", AN, 4'hF);
    @(negedge CLK);
    chk("en_c2_an", AN, 4'hE);
    chk("en_c2_seg", SEG, 8'h55);

`ifdef LED_SCAN_BRIGHTNESS_EN
    Bright = 3'd1;
    repeat (FR - 2) @(negedge CLK);
    nlit = 0;
    for (int c = 0; c < SL; c++) begin
      if (AN == 4'hE) nlit++;
      @(negedge CLK);
    end
    chk("bright1", nlit, 2);
    Bright = 3'd7;
    repeat (FR - SL) @(negedge CLK);
    nlit = 0;
    for (int c = 0; c < SL; c++) begin
      if (AN == 4'hE) nlit++;
      @(negedge CLK);
    end
    chk("bright7", nlit, 8);
`else
    nlit = 0;
`endif

    // random soak
    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      LED1  = 8'($urandom);
      LED2  = 8'($urandom);
      LED3  = 8'($urandom);
      LED4  = 8'($urandom);
      En    = ($urandom_range(0, 99) != 0);
      Reset = ($urandom_range(0, 499) != 0);
`ifdef LED_SCAN_BRIGHTNESS_EN
      Bright = 3'($urandom);
`endif
    end
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
